seq_multiplier: RTL
===================

# seq_multiplier

Sequential shift-and-add unsigned multiplier that consumes the gated operand pair produced by the operand-enable stage. It forms the arithmetic stage directly downstream of that stage. It captures both operands on a `start` pulse and iterates one partial product per clock. It presents a registered double-width product with a one-cycle `done` strobe. A new operation is accepted whenever it is not mid-computation, so back-to-back multiplies are supported.

## Interface
- `WIDTH`, default 4: operand width in bits; the product is `2*WIDTH` bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin a multiply; sampled on the rising edge.
- `a`  in  WIDTH  multiplicand, from the enable stage's gated A output.
- `b`  in  WIDTH  multiplier, from the enable stage's gated B output.
- `product`  out  2*WIDTH  registered result of the last completed multiply.
- `busy`  out  1  high while iterating; `start` is ignored while high.
- `done`  out  1  one-cycle strobe marking a newly valid `product`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE to CALC on `start`:
  - Latch `a` into the multiplicand register, zero-extended to 2*WIDTH.
  - Latch `b` into the multiplier shift register.
  - Clear the accumulator and the iteration counter.
- CALC, once per cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- Last CALC edge (counter reaches WIDTH-1):
  - Load `product` with the final accumulator value, including that edge's addition.
  - Go to DONE.
- DONE, which always lasts exactly one cycle:
  - `done`=1.
  - With `start` high, go to CALC and latch the new operands as from IDLE.
  - Otherwise go to IDLE.
- `start` while in CALC is ignored; no queuing, and the current operation is unaffected.
- Arithmetic:
  - Unsigned only.
  - The accumulator is 2*WIDTH bits and cannot overflow (max (2^W−1)^2 < 2^(2W)).
  - No early termination on a zero multiplier; the operation always takes WIDTH iterations.
- `product` holds its value until the next completion; it is never cleared by `start`.
- Outputs are decoded from the registered state: `busy` = (state==CALC), `done` = (state==DONE).

## Timing
- Reset values: state IDLE, `product`=0, `busy`=0, `done`=0, accumulator, counter and shift registers 0.
- Reset mid-CALC or in DONE:
  - The operation is abandoned and the next cycle is IDLE with all outputs at reset values.
  - No `done` is produced for the aborted operation.
- `start` sampled at edge E0:
  - `busy`=1 from E0 through E0+WIDTH.
  - `product` and `done` update at E0+WIDTH.
  - `done` is low again after E0+WIDTH+1 unless a new op chains.
- Latency: start to `done` is WIDTH clocks (4 for the default).
- Throughput: one result every WIDTH+1 clocks when `start` is held or re-asserted in DONE.
- `a` and `b` need only be valid on the accepting edge; later changes are ignored.
- `rst` and `start` on the same edge: reset wins.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum `mult_state_t` (IDLE, CALC, DONE);
  - the default `WIDTH` constant.
- Single module; no sub-module warranted.
- Counter width is `$clog2(WIDTH)`, or 1 bit minimum.

## Test plan
- After reset, apply `a`=9, `b`=5, `start` for 1 cycle -> `busy` high for 4 cycles, then `done`=1 for 1 cycle with `product`=8'h2D (45).
- `a`=15, `b`=15 -> `product`=8'hE1 (225). Also `a`=0, `b`=11 -> `product`=0 with the full 4-cycle latency.
- Pulse `start` with `a`=3, `b`=3 on the second CALC cycle of a 12×12 op -> the 12×12 result 8'h90 is produced, and no second `done` follows.
- Back-to-back:
  - Hold `start` with `a`=12, `b`=12, then change to `a`=4, `b`=9 before the first DONE.
  - Required response: `done` pulses show 8'h90 then 8'h24, separated by 5 cycles.
- Assert `rst` on the third CALC cycle of 9×5 -> next cycle `busy`=0, `done`=0, `product`=0, and no `done` pulse follows.
- `a` and `b` change every cycle during CALC -> the result still equals the product of the operands latched at `start`.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one partial product per clock, WIDTH
// iterations per operation, registered product with a one-cycle done strobe.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t        state, state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_sum;

  // A new operation can start from IDLE or from the single DONE cycle.
  assign accept    = start && (state != CALC);
  assign last_iter = (state == CALC) && (cnt == LAST_CNT);
  assign acc_sum   = acc + (mplr[0] ? mcand : '0);

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand <= {{WIDTH{1'b0}}, a};
        mplr  <= b;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == CALC) begin
        acc   <= acc_sum;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        cnt   <= cnt + 1'b1;
        // The final edge's addition goes straight into the product register.
        if (last_iter) product <= acc_sum;
      end
    end
  end

endmodule
